// File: rtl/clock_div_ctrl_pkg.sv
// Shared types and constants for the reference-clock divide-ratio controller.
// Includes the range check used to validate the gate/settle cycle parameters.
package clock_div_ctrl_pkg;

   localparam int CNT_W = 8;
   localparam int DIV_W = 8;

   typedef enum logic [2:0] {
      INIT,
      IDLE,
      GATE,
      APPLY,
      SETTLE,
      RESP
   } state_e;

   // The down-counter is loaded with N-1, so N may be anywhere in 1..2**CNT_W.
   function automatic bit cyclesInRange(input int n);
      return (n >= 1) && (n <= (1 << CNT_W));
   endfunction

endpackage

// File: rtl/clock_div_ctrl_if.sv
// Request/response bundle between the CSR/PMU requesters and the divider controller.
// The divider-facing outputs (ratio, enable, busy) travel in the same bundle.
interface clock_div_ctrl_if;
   import clock_div_ctrl_pkg::*;

   logic [1:0]       io_req_valid;
   logic [1:0]       io_req_ready;
   logic [DIV_W-1:0] io_req_div_0;
   logic [DIV_W-1:0] io_req_div_1;
   logic             io_resp_valid;
   logic             io_resp_id;
   logic             io_resp_err;
   logic [DIV_W-1:0] io_div;
   logic             io_clk_en;
   logic             io_busy;

   modport master (
      output io_req_valid, io_req_div_0, io_req_div_1,
      input  io_req_ready, io_resp_valid, io_resp_id, io_resp_err,
             io_div, io_clk_en, io_busy
   );

   modport slave (
      input  io_req_valid, io_req_div_0, io_req_div_1,
      output io_req_ready, io_resp_valid, io_resp_id, io_resp_err,
             io_div, io_clk_en, io_busy
   );

endinterface

// File: rtl/clock_div_ctrl_rr_arb2.sv
// Two-way round-robin arbiter; the pointer remembers the requester served last.
// After reset the pointer names requester 1, so requester 0 wins the first tie.
module rr_arb2 (
   input  logic       clock,
   input  logic       reset,
   input  logic [1:0] req_i,
   input  logic       advance_i,
   output logic [1:0] grant_o
);

   logic lastId_q;

   // On a tie the grant goes to whichever requester was not served last.
   always_comb begin
      grant_o = req_i;
      if (req_i == 2'b11) begin
         grant_o = lastId_q ? 2'b01 : 2'b10;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         lastId_q <= 1'b1;
      end else if (advance_i) begin
         lastId_q <= grant_o[1];
      end
   end

endmodule

// File: rtl/clock_div_ctrl.sv
// Sequences glitch-free divide-ratio changes: gate the divider, apply the new ratio,
// wait for it to settle, ungate and report completion to the requester that asked.
module clock_div_ctrl
   import clock_div_ctrl_pkg::*;
#(
   parameter logic [DIV_W-1:0] DIV_RESET     = 8'd1,
   parameter int               GATE_CYCLES   = 4,
   parameter int               SETTLE_CYCLES = 8
) (
   input  logic              clock,
   input  logic              reset,
   clock_div_ctrl_if.slave   bus
);

   if (!cyclesInRange(GATE_CYCLES)) begin : gBadGate
      $error("GATE_CYCLES must lie in 1..2**CNT_W");
   end
   if (!cyclesInRange(SETTLE_CYCLES)) begin : gBadSettle
      $error("SETTLE_CYCLES must lie in 1..2**CNT_W");
   end

   localparam logic [CNT_W-1:0] GATE_LOAD   = CNT_W'(GATE_CYCLES - 1);
   localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [DIV_W-1:0] div_q;
   logic [DIV_W-1:0] capDiv_q;
   logic             capId_q;
   logic             clkEn_q;
   logic             respValid_q;
   logic             respId_q;
   logic             respErr_q;

   logic [1:0]       grant;
   logic             handshake;
   logic [DIV_W-1:0] selDiv_d;
   logic             selId_d;

   rr_arb2 uArb (
      .clock     (clock),
      .reset     (reset),
      .req_i     (bus.io_req_valid),
      .advance_i (handshake),
      .grant_o   (grant)
   );

   // Ready is the arbiter grant, offered only while idle; the granted ratio is captured here.
   always_comb begin
      handshake = (state_q == IDLE) && (grant != 2'b00);
      selId_d   = grant[1];
      selDiv_d  = grant[1] ? bus.io_req_div_1 : bus.io_req_div_0;
   end

   // Single sequencer: every output it drives is registered, and the shared counter
   // is loaded with N-1 on entry to each timed state and leaves that state at zero.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= INIT;
         cnt_q       <= SETTLE_LOAD;
         div_q       <= DIV_RESET;
         capDiv_q    <= '0;
         capId_q     <= 1'b0;
         clkEn_q     <= 1'b0;
         respValid_q <= 1'b0;
         respId_q    <= 1'b0;
         respErr_q   <= 1'b0;
      end else begin
         respValid_q <= 1'b0;
         unique case (state_q)
            INIT: begin
               if (cnt_q == '0) begin
                  state_q <= IDLE;
                  clkEn_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            IDLE: begin
               if (handshake) begin
                  capDiv_q <= selDiv_d;
                  capId_q  <= selId_d;
                  // A zero ratio is refused and an unchanged ratio needs no gating.
                  if (selDiv_d == '0 || selDiv_d == div_q) begin
                     state_q     <= RESP;
                     respValid_q <= 1'b1;
                     respId_q    <= selId_d;
                     respErr_q   <= (selDiv_d == '0);
                  end else begin
                     state_q <= GATE;
                     clkEn_q <= 1'b0;
                     cnt_q   <= GATE_LOAD;
                  end
               end
            end
            GATE: begin
               if (cnt_q == '0) begin
                  state_q <= APPLY;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            APPLY: begin
               div_q   <= capDiv_q;
               state_q <= SETTLE;
               cnt_q   <= SETTLE_LOAD;
            end
            SETTLE: begin
               if (cnt_q == '0) begin
                  state_q     <= RESP;
                  clkEn_q     <= 1'b1;
                  respValid_q <= 1'b1;
                  respId_q    <= capId_q;
                  respErr_q   <= 1'b0;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            RESP: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= INIT;
            end
         endcase
      end
   end

   assign bus.io_req_ready  = (state_q == IDLE) ? grant : 2'b00;
   assign bus.io_resp_valid = respValid_q;
   assign bus.io_resp_id    = respId_q;
   assign bus.io_resp_err   = respErr_q;
   assign bus.io_div        = div_q;
   assign bus.io_clk_en     = clkEn_q;
   assign bus.io_busy       = (state_q != IDLE);

endmodule
